// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Memory-side end of the instruction-fetch interface. Holds a DEPTH x 64-bit
// word array and serves a byte-addressed read every cycle through a read
// pipeline of LATENCY stages. A host load port writes the program image. After
// reset, a clear sequencer fills every word with the stall word
// {STALL_INSTRUCTION, 32'h0} before any read or load is served.
//
// Optional feature (compile-time macro IMEM_WRITE_BYPASS_EN):
//   If defined, a read sampled in the same cycle as an accepted in-range load
//   to the same word returns that load's data. If undefined, the read returns
//   the pre-write contents.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset
//   mem_address    in   fetch byte address, sampled every cycle
//   mem_read_data  out  read word, instruction in bits [0:31]
//   mem_read_valid out  mem_read_data matches the address sampled LATENCY
//                       cycles earlier
//   ready          out  high once the clear sequence has completed
//   load_valid     in   host write request
//   load_address   in   host byte address
//   load_data      in   host write word
//   load_ready     out  write accepted when load_valid && load_ready
//   load_error     out  sticky out-of-range-load flag, cleared only by rst
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int          DEPTH             = 64,
  parameter int          ADDR_W            = 9,
  parameter int          LATENCY           = 1,
  parameter logic [0:31] STALL_INSTRUCTION = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:ADDR_W-1] mem_address,
  output logic [0:63]       mem_read_data,
  output logic              mem_read_valid,
  output logic              ready,
  input  logic              load_valid,
  input  logic [0:ADDR_W-1] load_address,
  input  logic [0:63]       load_data,
  output logic              load_ready,
  output logic              load_error
);

  localparam int IDX_W = ADDR_W - 3;
  localparam int AW    = $clog2(DEPTH);
  // One extra bit so the counter never wraps at the terminal count.
  localparam int CNT_W = AW + 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  localparam logic [0:63] STALL_WORD = {STALL_INSTRUCTION, 32'h0000_0000};

  // True when a word index addresses an existing array entry.
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return (int'(idx) < DEPTH);
  endfunction

  logic [0:63]          mem_r [0:DEPTH-1];
  logic [0:0]           state_r;
  logic [0:0]           state_nxt_s;
  logic [CNT_W-1:0]     clr_cnt_r;

  logic [IDX_W-1:0]     rd_idx_s;
  logic [IDX_W-1:0]     ld_idx_s;
  logic                 rd_in_range_s;
  logic                 ld_in_range_s;
  logic                 ld_accept_s;

  logic                 wr_en_s;
  logic [AW-1:0]        wr_addr_s;
  logic [0:63]          wr_data_s;

  logic                 rd_valid_s;
  logic [0:63]          rd_word_s;

  logic [0:63]          pipe_data_r [0:LATENCY-1];
  logic [LATENCY-1:0]   pipe_valid_r;

  // The byte offset within a word never affects which word is read or written.
  logic                 unused_offset_bits_s;
  assign unused_offset_bits_s = ^{mem_address[ADDR_W-3:ADDR_W-1],
                                  load_address[ADDR_W-3:ADDR_W-1]};

  // Address decode: drop the low three bits to get the word index.
  always_comb begin
    rd_idx_s      = mem_address[0:ADDR_W-4];
    ld_idx_s      = load_address[0:ADDR_W-4];
    rd_in_range_s = in_range(rd_idx_s);
    ld_in_range_s = in_range(ld_idx_s);
    ld_accept_s   = load_valid && load_ready;
  end

  // FSM next state and array write-port select (clear sequencer vs host load).
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = '0;
    wr_data_s   = STALL_WORD;
    case (state_r)
      ST_CLEAR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = clr_cnt_r[AW-1:0];
        wr_data_s = STALL_WORD;
        if (clr_cnt_r == CNT_W'(DEPTH - 1)) begin
          state_nxt_s = ST_SERVE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_SERVE: begin
        state_nxt_s = ST_SERVE;
        if (ld_accept_s && ld_in_range_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = ld_idx_s[AW-1:0];
          wr_data_s = load_data;
        end else begin
          wr_en_s   = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
      end
    endcase
  end

  // Read-word selection for the first pipeline stage.
  always_comb begin
    rd_valid_s = (state_r == ST_SERVE);
    if (!rd_in_range_s) begin
      rd_word_s = STALL_WORD;
`ifdef IMEM_WRITE_BYPASS_EN
    end else if (ld_accept_s && ld_in_range_s && (ld_idx_s == rd_idx_s)) begin
      // Forward the word being written this cycle instead of the stale entry.
      rd_word_s = load_data;
`endif
    end else begin
      rd_word_s = mem_r[rd_idx_s[AW-1:0]];
    end
  end

  // Control state: FSM, clear counter, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_CLEAR;
      clr_cnt_r  <= '0;
      ready      <= 1'b0;
      load_ready <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ready      <= (state_nxt_s == ST_SERVE);
      load_ready <= (state_nxt_s == ST_SERVE);
      if (state_r == ST_CLEAR) begin
        clr_cnt_r <= clr_cnt_r + CNT_W'(1);
      end else begin
        clr_cnt_r <= clr_cnt_r;
      end
      if (ld_accept_s && !ld_in_range_s) begin
        load_error <= 1'b1;
      end else begin
        load_error <= load_error;
      end
    end
  end

  // Storage array write port; contents are initialised by the clear sequence.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Read pipeline: data stages only advance on valid, so the output word
  // holds its last value while valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data_r[i] <= STALL_WORD;
      end
    end else begin
      pipe_valid_r[0] <= rd_valid_s;
      if (rd_valid_s) begin
        pipe_data_r[0] <= rd_word_s;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        if (pipe_valid_r[i-1]) begin
          pipe_data_r[i] <= pipe_data_r[i-1];
        end
      end
    end
  end

  assign mem_read_data  = pipe_data_r[LATENCY-1];
  assign mem_read_valid = pipe_valid_r[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//
// Directed bench for imem_responder. Two instances share one stimulus stream:
//   dut_a : DEPTH=64, LATENCY=1 (default configuration)
//   dut_b : DEPTH=32, LATENCY=3 (latency pipelining and out-of-range loads)
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at
// the same point, so every sample reflects the most recent edge.
// -----------------------------------------------------------------------------
module tb_imem_responder;

  localparam logic [31:0] STALL   = 32'h0000_0013;
  localparam logic [63:0] STALL_W = {STALL, 32'h0000_0000};

  localparam logic [63:0] W_LOAD = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W0     = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W1     = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] W2     = 64'h0F0F_0F0F_F0F0_F0F0;
  localparam logic [63:0] W_X    = 64'h7777_8888_9999_AAAA;
  localparam logic [63:0] W_END  = 64'h5A5A_0000_FFFF_1234;
  localparam logic [63:0] W_OLD  = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] W_NEW  = 64'hDEAD_BEEF_0000_0001;
`ifdef IMEM_WRITE_BYPASS_EN
  localparam logic [63:0] W_SAME = W_NEW;
`else
  localparam logic [63:0] W_SAME = W_OLD;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [0:8]  mem_address;
  logic        load_valid;
  logic [0:8]  load_address;
  logic [0:63] load_data;

  logic [0:63] a_data, b_data;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic        a_lready, b_lready, a_lerr, b_lerr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(64), .ADDR_W(9), .LATENCY(1), .STALL_INSTRUCTION(STALL)) dut_a (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read_data(a_data),
    .mem_read_valid(a_valid), .ready(a_ready), .load_valid(load_valid),
    .load_address(load_address), .load_data(load_data), .load_ready(a_lready),
    .load_error(a_lerr));

  imem_responder #(.DEPTH(32), .ADDR_W(9), .LATENCY(3), .STALL_INSTRUCTION(STALL)) dut_b (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read_data(b_data),
    .mem_read_valid(b_valid), .ready(b_ready), .load_valid(load_valid),
    .load_address(load_address), .load_data(load_data), .load_ready(b_lready),
    .load_error(b_lerr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles after reset release until each instance reports ready;
  // flags any valid seen from an instance that is still clearing.
  task automatic wait_ready(output int ca, output int cb, output bit vseen);
    ca = 0;
    cb = 0;
    vseen = 1'b0;
    for (int c = 1; c <= 200 && ca == 0; c++) begin
      if (a_ready && ca == 0) ca = c;
      if (b_ready && cb == 0) cb = c;
      if ((!a_ready && a_valid) || (!b_ready && b_valid)) vseen = 1'b1;
      if (ca == 0) tick();
    end
  endtask

  initial begin
    int  ca, cb;
    bit  vseen;

    rst          = 1'b1;
    load_valid   = 1'b0;
    load_address = 9'h000;
    load_data    = 64'h0;
    mem_address  = 9'h000;
    tick();
    tick();

    // Reset state
    chk("rst_a_data",   a_data,   STALL_W);
    chk("rst_a_valid",  64'(a_valid),  64'd0);
    chk("rst_a_ready",  64'(a_ready),  64'd0);
    chk("rst_a_lready", 64'(a_lready), 64'd0);
    chk("rst_a_lerr",   64'(a_lerr),   64'd0);
    chk("rst_b_valid",  64'(b_valid),  64'd0);

    // Clear sequence length
    rst = 1'b0;
    wait_ready(ca, cb, vseen);
    chk("clear_cycles_a", 64'(ca), 64'd65);
    chk("clear_cycles_b", 64'(cb), 64'd33);
    chk("clear_no_valid", 64'(vseen), 64'd0);

    // Cleared contents read back as the stall word
    mem_address = 9'h1F8;
    tick();
    chk("clr_1f8_data",  a_data, STALL_W);
    chk("clr_1f8_valid", 64'(a_valid), 64'd1);
    mem_address = 9'h0A0;
    tick();
    chk("clr_0a0_data",  a_data, STALL_W);

    // Single load then aligned and unaligned reads
    load_valid   = 1'b1;
    load_address = 9'h010;
    load_data    = W_LOAD;
    chk("lready_a", 64'(a_lready), 64'd1);
    tick();
    load_valid  = 1'b0;
    mem_address = 9'h010;
    tick();
    chk("rd_010", a_data, W_LOAD);
    mem_address = 9'h013;
    tick();
    chk("rd_013", a_data, W_LOAD);
    chk("rd_013_valid", 64'(a_valid), 64'd1);

    // Back-to-back loads, then a streamed read
    load_valid = 1'b1;
    load_address = 9'h000; load_data = W0; tick();
    load_address = 9'h008; load_data = W1; tick();
    load_address = 9'h010; load_data = W2; tick();
    load_valid = 1'b0;
    mem_address = 9'h000; tick();
    chk("stream_a0", a_data, W0);
    mem_address = 9'h008; tick();
    chk("stream_a1", a_data, W1);
    mem_address = 9'h010; tick();
    chk("stream_a2", a_data, W2);
    chk("stream_b0", b_data, W0);
    chk("stream_b0_valid", 64'(b_valid), 64'd1);
    mem_address = 9'h1F8; tick();
    chk("stream_b1", b_data, W1);
    chk("stream_b1_valid", 64'(b_valid), 64'd1);
    tick();
    chk("stream_b2", b_data, W2);
    chk("stream_b2_valid", 64'(b_valid), 64'd1);
    tick();
    chk("b_oor_read", b_data, STALL_W);
    chk("b_oor_read_valid", 64'(b_valid), 64'd1);

    // Load to 0x100: in range for dut_a, out of range for dut_b
    load_valid = 1'b1; load_address = 9'h100; load_data = W_X; tick();
    load_valid = 1'b0;
    chk("lerr_b_set", 64'(b_lerr), 64'd1);
    chk("lerr_a_clr", 64'(a_lerr), 64'd0);
    mem_address = 9'h100; tick();
    chk("rd_a_100", a_data, W_X);
    mem_address = 9'h000; tick();
    chk("rd_a_000", a_data, W0);
    tick();
    chk("rd_b_100_oor", b_data, STALL_W);
    tick();
    chk("rd_b_000_unchanged", b_data, W0);
    chk("lerr_b_sticky", 64'(b_lerr), 64'd1);

    // Top word of dut_a
    load_valid = 1'b1; load_address = 9'h1F8; load_data = W_END; tick();
    load_valid = 1'b0;
    mem_address = 9'h1F8; tick();
    chk("rd_a_1f8", a_data, W_END);
    chk("lerr_a_still_clr", 64'(a_lerr), 64'd0);

    // Same-cycle load and read of one word
    load_valid = 1'b1; load_address = 9'h020; load_data = W_OLD; tick();
    load_data = W_NEW; mem_address = 9'h020; tick();
    load_valid = 1'b0;
    chk("same_cycle_a", a_data, W_SAME);
    tick();
    chk("after_write_a", a_data, W_NEW);
    tick();
    chk("same_cycle_b", b_data, W_SAME);
    tick();
    chk("after_write_b", b_data, W_NEW);

    // Reset with reads in flight
    mem_address = 9'h010;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_a_valid", 64'(a_valid), 64'd0);
    chk("mid_rst_b_valid", 64'(b_valid), 64'd0);
    chk("mid_rst_a_data",  a_data, STALL_W);
    chk("mid_rst_b_data",  b_data, STALL_W);
    chk("mid_rst_a_ready", 64'(a_ready), 64'd0);
    chk("mid_rst_b_lerr",  64'(b_lerr), 64'd0);
    rst = 1'b0;
    wait_ready(ca, cb, vseen);
    chk("reclear_cycles_a", 64'(ca), 64'd65);
    chk("reclear_no_valid", 64'(vseen), 64'd0);
    tick();
    chk("reclear_rd_010", a_data, STALL_W);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the fetch interface. Serves byte-addressed reads issued by the fetch stage on mem_address and returns 64-bit words on mem_read_data.
- Holds a DEPTH x 64 storage array and a read pipeline of configurable latency.
- Provides a host load port for writing the program image.
- After reset, a clear sequencer fills every word with STALL_INSTRUCTION before any real data is served.

Parameters:
- DEPTH, 64, number of 64-bit words; must be a power of two, ≤ 2^(ADDR_W-3).
- ADDR_W, 9, width of the byte address on both the read and load ports.
- LATENCY, 1, cycles from address sample to data valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_address  in  [0:ADDR_W-1]  fetch byte address, sampled every cycle.
- mem_read_data  out  [0:63]  read word; the instruction sits in bits [0:31].
- mem_read_valid  out  1  mem_read_data corresponds to the address sampled LATENCY cycles earlier.
- ready  out  1  high once the clear sequence has completed.
- load_valid  in  1  host write request.
- load_address  in  [0:ADDR_W-1]  host byte address.
- load_data  in  [0:63]  host write word.
- load_ready  out  1  a write is accepted this cycle when load_valid && load_ready.
- load_error  out  1  sticky flag; set by an out-of-range load; cleared only by rst.

Behaviour:
- Reset (synchronous; also applies mid-operation):
  - mem_read_data = {STALL_INSTRUCTION, 32'b0}
  - mem_read_valid = 0, ready = 0, load_ready = 0, load_error = 0
  - read pipeline flushed to invalid
  - clear counter = 0
  - FSM -> CLEAR
- FSM states:
  - CLEAR: each cycle writes {STALL_INSTRUCTION, 32'b0} to word[counter] and increments the counter. Exits after word DEPTH-1 is written (exactly DEPTH cycles). Reads are ignored in this state and no valid is produced. load_ready = 0.
  - SERVE: ready = 1, load_ready = 1. There is no exit except rst.
- Address mapping:
  - Word index = address bits [0:ADDR_W-4], i.e. the low 3 bits are dropped, so unaligned addresses read the containing word.
  - Index ≥ DEPTH is out of range.
  - Out-of-range read returns {STALL_INSTRUCTION, 32'b0} with valid asserted.
  - Out-of-range load is dropped and sets load_error.
- Read pipeline (SERVE only):
  - Every cycle the current mem_address is sampled.
  - The data appears LATENCY cycles later with mem_read_valid = 1.
  - One read per cycle, fully pipelined, no backpressure.
  - mem_read_data holds its last value while valid = 0.
- Writes:
  - An accepted load writes at the clock edge.
  - A read of the same word in the same cycle returns the old data; see the optional feature for bypass.
  - Back-to-back loads are accepted at one per cycle.
- Widths: the counter is clog2(DEPTH)+1 bits to avoid wrap at the terminal count. There is no arithmetic on data.

Optional Feature:
- Macro: IMEM_WRITE_BYPASS_EN.
- Defined: a read sampled in the same cycle as an accepted in-range load to the same word returns load_data, LATENCY cycles later. Applies to SERVE only.
- Undefined: that read returns the pre-write contents. There is no forwarding logic.

Test Plan:
- rst=1 for 2 cycles, then release -> ready=0 for exactly 64 cycles, ready=1 on cycle 65. Reading any address 0x000..0x1F8 then returns {STALL_INSTRUCTION, 32'b0}.
- SERVE, LATENCY=1: load 0x1111_2222_3333_4444 at address 0x010, then read 0x010 and 0x013 -> both return 0x1111_2222_3333_4444 with valid one cycle after each address.
- LATENCY=3: stream addresses 0x000, 0x008, 0x010 on consecutive cycles after loading distinct words there -> the three words appear in order on cycles +3, +4, +5 with continuous valid.
- Load address 0x1F8 succeeds. With DEPTH=32, load to 0x100 -> array unchanged, load_error=1 and stays set until rst.
- Same-cycle load 0xDEAD_BEEF_0000_0001 and read at 0x020 (old value 0xA5A5…) -> returns 0xA5A5… without IMEM_WRITE_BYPASS_EN and 0xDEAD_BEEF_0000_0001 with it; the next read returns the new value in both builds.
- Assert rst during SERVE with reads in flight -> mem_read_valid=0 on the next cycle, no stale data emerges, and the CLEAR sequence restarts for 64 cycles.
